// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing header: default 640x480 totals and the common coordinate types.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Used by vga_timing_gen and by the downstream porch/sync stage, so both
// agree on the raw frame geometry.
package vga_timing_gen_pkg;

  localparam int COORD_W = 11;
  localparam int FRAME_W = 8;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [FRAME_W-1:0] frame_t;

  // 640x480 @ 60 Hz totals, including blanking.
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_TOTAL  = 525;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// Modulo counter with enable; reports wrap and exposes its next value.
// Latency: count updates on the clock after i_en; o_wrap/o_count_nxt are combinational.
// Backpressure: none; the counter holds whenever i_en is low.
//
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset (count resets to MODULUS-1)
//   i_en            advance by one, wrapping MODULUS-1 -> 0
//   o_count         registered count
//   o_count_nxt     value o_count takes at the next edge
//   o_wrap          high when this enabled tick wraps to 0
module mod_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int MODULUS = 2
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_en,
  output coord_t o_count,
  output coord_t o_count_nxt,
  output logic   o_wrap
);

  localparam coord_t LAST = coord_t'(MODULUS - 1);

  coord_t count_q;

  assign o_wrap      = i_en && (count_q == LAST);
  assign o_count_nxt = !i_en  ? count_q :
                       o_wrap ? '0      :
                                count_q + coord_t'(1);

  // Reset to the last position so the first enabled tick lands on 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= LAST;
    end else begin
      count_q <= o_count_nxt;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raw VGA raster generator: position, active/sync decode, line/frame pulses, frame count.
// Latency: all outputs registered together; one position step per enabled clock.
// Backpressure: i_enable is the pixel tick; with it low everything holds and pulses drop.
//
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_enable         pixel tick
//   o_x, o_y         current column / row
//   o_active         inside the visible window
//   o_hsync/o_vsync  raw line/frame sync (visible-region flags, porches added downstream)
//   o_line_start     one-clock pulse on entering x = 0
//   o_frame_start    one-clock pulse on entering (0,0)
//   o_frame          frame count modulo 256
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int WIDTH         = VGA_H_TOTAL,
  parameter int HEIGHT        = VGA_V_TOTAL,
  parameter int WIDTH_ACTIVE  = VGA_H_ACTIVE,
  parameter int HEIGHT_ACTIVE = VGA_V_ACTIVE
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_enable,
  output logic [10:0]  o_x,
  output logic [10:0]  o_y,
  output logic         o_active,
  output logic         o_hsync,
  output logic         o_vsync,
  output logic         o_line_start,
  output logic         o_frame_start,
  output logic [7:0]   o_frame
);

  localparam coord_t X_ACT = coord_t'(WIDTH_ACTIVE);
  localparam coord_t Y_ACT = coord_t'(HEIGHT_ACTIVE);

  coord_t x_q, x_nxt, y_q, y_nxt;
  logic   x_wrap, y_wrap;
  logic   hsync_q, vsync_q, line_start_q, frame_start_q;
  frame_t frame_q;

  mod_counter #(.MODULUS(WIDTH)) u_col (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_enable),
    .o_count     (x_q),
    .o_count_nxt (x_nxt),
    .o_wrap      (x_wrap)
  );

  // Rows step only when the column wraps, so y_wrap implies x_wrap.
  mod_counter #(.MODULUS(HEIGHT)) u_row (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (x_wrap),
    .o_count     (y_q),
    .o_count_nxt (y_nxt),
    .o_wrap      (y_wrap)
  );

  // Flags are decoded from the counters' next values so that they land in
  // the same cycle as the position they describe. The reset values (all 0)
  // match the decode of the reset position (WIDTH-1, HEIGHT-1), which lies
  // outside the visible window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_q       <= '1;
    end else begin
      hsync_q       <= (x_nxt < X_ACT);
      vsync_q       <= (y_nxt < Y_ACT);
      line_start_q  <= x_wrap;
      frame_start_q <= y_wrap;
      if (y_wrap) begin
        frame_q <= frame_q + frame_t'(1);
      end
    end
  end

  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_active      = hsync_q && vsync_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_frame       = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  localparam int W  = 10;
  localparam int H  = 6;
  localparam int WA = 8;
  localparam int HA = 4;
  localparam int N  = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [10:0] o_x, o_y;
  logic        o_active, o_hsync, o_vsync, o_line_start, o_frame_start;
  logic [7:0]  o_frame;

  vga_timing_gen #(
    .WIDTH(W), .HEIGHT(H), .WIDTH_ACTIVE(WA), .HEIGHT_ACTIVE(HA)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (en),
    .o_x           (o_x),
    .o_y           (o_y),
    .o_active      (o_active),
    .o_hsync       (o_hsync),
    .o_vsync       (o_vsync),
    .o_line_start  (o_line_start),
    .o_frame_start (o_frame_start),
    .o_frame       (o_frame)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: n = enabled ticks since the last reset. Tick k (k>=1)
  // lands on raster index k-1 in row-major order; n = 0 is the reset position.
  int n       = 0;
  bit last_en = 1'b0;

  function automatic int ex_x();
    return (n == 0) ? W - 1 : (n - 1) % W;
  endfunction

  function automatic int ex_y();
    return (n == 0) ? H - 1 : ((n - 1) / W) % H;
  endfunction

  function automatic int ex_frame();
    return (n == 0) ? 255 : ((n - 1) / N) % 256;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (tick %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_all();
    int ex, ey;
    ex = ex_x();
    ey = ex_y();
    chk("x",           int'(o_x),           ex);
    chk("y",           int'(o_y),           ey);
    chk("frame",       int'(o_frame),       ex_frame());
    chk("active",      int'(o_active),      int'(ex < WA && ey < HA));
    chk("hsync",       int'(o_hsync),       int'(ex < WA));
    chk("vsync",       int'(o_vsync),       int'(ey < HA));
    chk("line_start",  int'(o_line_start),  int'(last_en && n > 0 && ex == 0));
    chk("frame_start", int'(o_frame_start), int'(last_en && n > 0 && ex == 0 && ey == 0));
  endtask

  task automatic step(input bit e);
    en = e;
    @(posedge clk);
    #1;
    if (e) n++;
    last_en = e;
    check_all();
  endtask

  initial begin
    // Reset held with the tick high: position parked at (W-1,H-1), flags low.
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    #2 rst_n = 1'b1;

    // First tick enters (0,0) with both pulses and frame 0; then one full
    // frame plus one tick, crossing every line wrap and the frame wrap.
    step(1'b1);
    chk("first_frame_start", int'(o_frame_start), 1);
    for (int i = 0; i < N; i++) step(1'b1);
    chk("frame_after_60", int'(o_frame), 1);

    // Alternating tick: one advance per two clocks, pulses never stretch.
    for (int i = 0; i < 40; i++) step(i % 2 == 0);

    // Enough frames to carry the frame counter through 255 -> 0.
    for (int i = 0; i < N * 257; i++) step(1'b1);

    // Random tick pattern.
    for (int i = 0; i < 300; i++) step(1'(($urandom_range(0, 3) != 0)));

    // Walk to (5,2) (bounded), then reset asynchronously between edges.
    for (int k = 0; k < 2 * N && !(ex_x() == 5 && ex_y() == 2); k++) step(1'b1);
    chk("at_5_2_x", int'(o_x), 5);
    chk("at_5_2_y", int'(o_y), 2);
    en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n = 0;
    last_en = 1'b0;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2 rst_n = 1'b1;
    step(1'b1);
    chk("post_reset_frame_start", int'(o_frame_start), 1);

    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
